// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus dispatch FSM that paces one-cycle tx_start pulses into a UART transmitter via tx_busy.
// Define UART_TX_FEEDER_STATS_EN to add sent_count, drop_count and timeout_err outputs.
module uart_tx_feeder #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AW           = $clog2(DEPTH),
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy
`ifdef UART_TX_FEEDER_STATS_EN
  ,
  output logic [15:0]   sent_count,
  output logic [7:0]    drop_count,
  output logic          timeout_err
`endif
);

  localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BUSY_TIMEOUT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] START   = 2'd1;
  localparam logic [1:0] WAIT_HI = 2'd2;
  localparam logic [1:0] WAIT_LO = 2'd3;

  logic [7:0]    mem_q [DEPTH];
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop, timeout;

  always_comb begin
    // full is the registered flag, so a pop in the same cycle never frees a slot for this push
    push       = wr_en && !full_q;
    pop        = (state_q == IDLE) && !empty_q && !tx_busy;
    overflow_d = wr_en && full_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == '0);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          if (cnt_d == CNT_MAX) begin
            timeout = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_LO: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign tx_start = (state_q == START);
  assign tx_data  = tx_data_q;

`ifdef UART_TX_FEEDER_STATS_EN
  logic [15:0] sent_count_q, sent_count_d;
  logic [7:0]  drop_count_q, drop_count_d;
  logic        timeout_err_q, timeout_err_d;

  always_comb begin
    sent_count_d  = pop ? sent_count_q + 1'b1 : sent_count_q;
    drop_count_d  = (overflow_d && drop_count_q != '1) ? drop_count_q + 1'b1 : drop_count_q;
    timeout_err_d = timeout_err_q | timeout;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sent_count_q  <= '0;
      drop_count_q  <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      sent_count_q  <= sent_count_d;
      drop_count_q  <= drop_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign sent_count  = sent_count_q;
  assign drop_count  = drop_count_q;
  assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: directed scenarios plus a randomized queue-based scoreboard.
// Build with +define+UART_TX_FEEDER_STATS_EN to also check the statistics outputs.
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
  localparam int TMO   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       full, empty, overflow, tx_start;
  logic [4:0] level;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       man_busy = 1'b0;
  logic       uart_busy = 1'b0;
  bit         uart_en = 1'b0;
  int         uart_cnt = 0;
  int         hold = 4;
`ifdef UART_TX_FEEDER_STATS_EN
  logic [15:0] sent_count;
  logic [7:0]  drop_count;
  logic        timeout_err;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  assign tx_busy = man_busy | uart_busy;

  uart_tx_feeder #(.DEPTH(DEPTH), .BUSY_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
`ifdef UART_TX_FEEDER_STATS_EN
    , .sent_count(sent_count), .drop_count(drop_count), .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // UART transmitter model: busy rises on the edge that samples tx_start, stays high for 'hold' cycles
  always @(posedge clk) begin
    if (uart_cnt > 0) begin
      uart_cnt <= uart_cnt - 1;
      if (uart_cnt == 1) uart_busy <= 1'b0;
    end else if (uart_en && tx_start) begin
      uart_busy <= 1'b1;
      uart_cnt  <= hold;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    wr_en    = 1'b0;
    man_busy = 1'b0;
    uart_en  = 1'b0;
    for (int i = 0; i < 5000 && tx_busy; i++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    int starts;
    do_reset();
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (level !== 5'd0)    begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
`ifdef UART_TX_FEEDER_STATS_EN
    checks++; if (sent_count !== 16'd0 || drop_count !== 8'd0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL reset_stats: got sent=%0d drop=%0d terr=%b expected 0/0/0", sent_count, drop_count, timeout_err);
    end
`endif
    starts = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx_start === 1'b1) starts++;
    end
    checks++; if (starts != 0)       begin errors++; $display("FAIL idle_no_start: got %0d starts expected 0", starts); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL idle_tx_data: got %h expected 00", tx_data); end
  endtask

  task automatic test_single();
    int push_cyc, first, starts;
    do_reset();
    uart_en = 1'b1;
    hold    = 4340;
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    tick();
    push_cyc = cyc;
    wr_en    = 1'b0;
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty: got %b expected 0", empty); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level: got %0d expected 1", level); end
    starts = 0;
    first  = -1;
    for (int i = 0; i < 4400; i++) begin
      tick();
      if (tx_start === 1'b1) begin
        starts++;
        if (first < 0) begin
          first = cyc;
          checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", tx_data); end
          checks++; if (level !== 5'd0)    begin errors++; $display("FAIL single_pop_level: got %0d expected 0", level); end
        end
      end
    end
    checks++; if (starts != 1) begin errors++; $display("FAIL single_count: got %0d starts expected 1", starts); end
    // IDLE sees the byte on the edge after the push, so tx_start is up right after that edge
    checks++; if (first != push_cyc + 1) begin errors++; $display("FAIL single_latency: got cycle %0d expected %0d", first, push_cyc + 1); end
  endtask

  task automatic test_burst();
    int idx, fall_cyc;
    logic prev_busy;
    do_reset();
    uart_en  = 1'b1;
    hold     = 20;
    man_busy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      tick();
    end
    checks++; if (full !== 1'b1)      begin errors++; $display("FAIL burst_full: got %b expected 1", full); end
    checks++; if (level !== 5'd16)    begin errors++; $display("FAIL burst_level: got %0d expected 16", level); end
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL burst_no_ovf: got %b expected 0", overflow); end
    wr_data = 8'h11;
    tick();
    wr_en = 1'b0;
    checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL burst_ovf: got %b expected 1", overflow); end
    checks++; if (level !== 5'd16)    begin errors++; $display("FAIL burst_ovf_level: got %0d expected 16", level); end
    tick();
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL burst_ovf_pulse: got %b expected 0", overflow); end
`ifdef UART_TX_FEEDER_STATS_EN
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL burst_drop_count: got %0d expected 1", drop_count); end
`endif
    man_busy  = 1'b0;
    prev_busy = 1'b1;
    idx       = 0;
    fall_cyc  = -100;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (prev_busy && !tx_busy) fall_cyc = cyc;
      if (tx_start === 1'b1) begin
        checks++; if (idx >= 16 || tx_data !== 8'(idx + 1)) begin
          errors++; $display("FAIL burst_order: got %h at index %0d expected %h", tx_data, idx, 8'(idx + 1));
        end
        if (idx > 0) begin
          checks++; if (cyc - fall_cyc != 2) begin
            errors++; $display("FAIL burst_gap: got %0d cycles expected 2 (byte %0d)", cyc - fall_cyc, idx);
          end
        end
        idx++;
      end
      prev_busy = tx_busy;
    end
    checks++; if (idx != 16)        begin errors++; $display("FAIL burst_count: got %0d bytes expected 16", idx); end
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL burst_drained: got empty=%b expected 1", empty); end
`ifdef UART_TX_FEEDER_STATS_EN
    checks++; if (sent_count !== 16'd16) begin errors++; $display("FAIL burst_sent_count: got %0d expected 16", sent_count); end
`endif
  endtask

  task automatic test_busy_hold();
    int starts, rel_cyc, got;
    do_reset();
    uart_en  = 1'b1;
    hold     = 10;
    man_busy = 1'b1;
    wr_en    = 1'b1;
    wr_data  = 8'h3C;
    tick();
    wr_en  = 1'b0;
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_start === 1'b1) starts++;
    end
    checks++; if (starts != 0)    begin errors++; $display("FAIL hold_no_start: got %0d starts expected 0", starts); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL hold_level: got %0d expected 1", level); end
    man_busy = 1'b0;
    rel_cyc  = cyc;
    got      = -1;
    for (int i = 0; i < 10 && got < 0; i++) begin
      tick();
      if (tx_start === 1'b1) begin
        got = cyc;
        checks++; if (tx_data !== 8'h3C) begin errors++; $display("FAIL hold_data: got %h expected 3c", tx_data); end
      end
    end
    checks++; if (got != rel_cyc + 1) begin errors++; $display("FAIL hold_latency: got cycle %0d expected %0d", got, rel_cyc + 1); end
  endtask

  task automatic test_timeout();
    int e2, n, s1;
    logic [7:0] d1;
    do_reset();
    wr_en   = 1'b1;
    wr_data = 8'h55;
    tick();
    wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    e2    = cyc;
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h55) begin
      errors++; $display("FAIL tmo_first: got start=%b data=%h expected 1/55", tx_start, tx_data);
    end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL tmo_push_pop_level: got %0d expected 1", level); end
`ifdef UART_TX_FEEDER_STATS_EN
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_err_early: got %b expected 0", timeout_err); end
`endif
    n  = 0;
    s1 = -1;
    d1 = 8'h00;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (tx_start === 1'b1) begin
        n++;
        if (s1 < 0) begin s1 = cyc; d1 = tx_data; end
      end
    end
    checks++; if (n != 1)       begin errors++; $display("FAIL tmo_second_count: got %0d starts expected 1", n); end
    checks++; if (d1 !== 8'hAA) begin errors++; $display("FAIL tmo_second_data: got %h expected aa", d1); end
    // one START cycle, BUSY_TIMEOUT cycles in WAIT_HI, then IDLE relaunches
    checks++; if (s1 - e2 != TMO + 2) begin errors++; $display("FAIL tmo_spacing: got %0d expected %0d", s1 - e2, TMO + 2); end
`ifdef UART_TX_FEEDER_STATS_EN
    checks++; if (timeout_err !== 1'b1)  begin errors++; $display("FAIL tmo_err: got %b expected 1", timeout_err); end
    checks++; if (sent_count !== 16'd2)  begin errors++; $display("FAIL tmo_sent_count: got %0d expected 2", sent_count); end
`endif
  endtask

  task automatic test_reset_mid();
    int starts;
    bit seen;
    do_reset();
    uart_en = 1'b1;
    hold    = 30;
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'($urandom);
      tick();
    end
    wr_en = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (tx_busy) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_busy_wait: got no busy expected busy within 20 cycles"); end
    tick();
    tick();
    checks++; if (level !== 5'd2) begin errors++; $display("FAIL mid_level_before: got %0d expected 2", level); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL mid_flags: got level=%0d empty=%b full=%b expected 0/1/0", level, empty, full);
    end
    checks++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin
      errors++; $display("FAIL mid_tx: got start=%b data=%h expected 0/00", tx_start, tx_data);
    end
    starts = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx_start === 1'b1) starts++;
    end
    checks++; if (starts != 0) begin errors++; $display("FAIL mid_dropped: got %0d starts expected 0", starts); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] d, last;
    logic prev_busy;
    int pre, accepted, drops;
    bit acc;
    do_reset();
    uart_en   = 1'b1;
    accepted  = 0;
    drops     = 0;
    last      = 8'h00;
    prev_busy = tx_busy;
    for (int i = 0; i < 3000; i++) begin
      hold    = int'($urandom_range(1, 12));
      wr_en   = (i < 2400) ? 1'($urandom_range(0, 1)) : 1'b0;
      d       = 8'($urandom);
      wr_data = d;
      pre     = q.size();
      acc     = wr_en && (pre < DEPTH);
      tick();
      if (tx_start === 1'b1) begin
        checks++; if (prev_busy || q.size() == 0 || tx_data !== q[0]) begin
          errors++; $display("FAIL rand_tx: got data=%h prev_busy=%b expected %h", tx_data, prev_busy, (q.size() > 0) ? q[0] : 8'h00);
        end
        if (q.size() > 0) last = q.pop_front();
      end else begin
        checks++; if (tx_data !== last) begin errors++; $display("FAIL rand_hold_data: got %h expected %h", tx_data, last); end
      end
      if (acc) begin
        q.push_back(d);
        accepted++;
      end else if (wr_en) begin
        drops++;
      end
      checks++; if (overflow !== (wr_en && !acc)) begin
        errors++; $display("FAIL rand_overflow: got %b expected %b", overflow, wr_en && !acc);
      end
      checks++; if (level !== 5'(q.size()) || full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin
        errors++; $display("FAIL rand_flags: got level=%0d full=%b empty=%b expected %0d", level, full, empty, q.size());
      end
      prev_busy = tx_busy;
    end
    wr_en = 1'b0;
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d left expected 0", q.size()); end
`ifdef UART_TX_FEEDER_STATS_EN
    checks++; if (sent_count !== 16'(accepted)) begin errors++; $display("FAIL rand_sent: got %0d expected %0d", sent_count, accepted); end
    checks++; if (drop_count !== 8'((drops > 255) ? 255 : drops)) begin
      errors++; $display("FAIL rand_drop_sat: got %0d expected %0d", drop_count, (drops > 255) ? 255 : drops);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_busy_hold();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
